// File: rtl/four_two_priority_encoder.sv
// Registered 4-to-2 priority encoder with request capture and valid/ack handshake.
// Define FOUR_TWO_ROUND_ROBIN_EN for rotating priority; default is fixed 3>2>1>0.
module four_two_priority_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       Cs,
    input  logic [3:0] Req_n,
    input  logic       Ack,
    output logic       A1,
    output logic       A0,
    output logic       Valid,
    output logic [3:0] Pend
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_nxt;
    logic [3:0] pend, pend_nxt, pend_clr, pend_set;
    logic [1:0] code, code_nxt, win;
    logic       any_pend;

    assign any_pend = |pend;

`ifdef FOUR_TWO_ROUND_ROBIN_EN
    logic [1:0] last;
    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;

    // rot[3] is the top-priority index (last+3), rot[0] is last itself
    always_comb begin
        dbl = {pend, pend};
        rot = dbl[{1'b0, last} +: 4];
        if (rot[3])      off = 2'd3;
        else if (rot[2]) off = 2'd2;
        else if (rot[1]) off = 2'd1;
        else             off = 2'd0;
        win = last + off;
    end

    always_ff @(posedge clk) begin
        if (rst)
            last <= 2'd0;
        else if (state == GRANT && Ack)
            last <= code;
    end
`else
    always_comb begin
        if (pend[3])      win = 2'd3;
        else if (pend[2]) win = 2'd2;
        else if (pend[1]) win = 2'd1;
        else              win = 2'd0;
    end
`endif

    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        pend_clr  = 4'b0000;
        case (state)
            IDLE: begin
                if (any_pend) begin
                    state_nxt = GRANT;
                    code_nxt  = win;
                end
            end
            GRANT: begin
                if (Ack) begin
                    state_nxt = IDLE;
                    pend_clr  = 4'b0001 << code;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // set after clear: a line still held low re-pends on the ack edge
    assign pend_set = Cs ? 4'b0000 : ~Req_n;
    assign pend_nxt = (pend & ~pend_clr) | pend_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend  <= 4'b0000;
            code  <= 2'd0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            code  <= code_nxt;
        end
    end

    assign A1    = code[1];
    assign A0    = code[0];
    assign Valid = (state == GRANT);
    assign Pend  = pend;
endmodule

// File: tb/tb_four_two_priority_encoder.sv
// Self-checking bench for four_two_priority_encoder: behavioural model
// compared every cycle, plus directed vectors with literal expectations.
module tb_four_two_priority_encoder;
    logic       clk;
    logic       rst;
    logic       Cs;
    logic [3:0] Req_n;
    logic       Ack;
    logic       A1;
    logic       A0;
    logic       Valid;
    logic [3:0] Pend;

    int checks = 0;
    int errors = 0;

    four_two_priority_encoder dut (
        .clk   (clk),
        .rst   (rst),
        .Cs    (Cs),
        .Req_n (Req_n),
        .Ack   (Ack),
        .A1    (A1),
        .A0    (A0),
        .Valid (Valid),
        .Pend  (Pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: set of pending indices, whether a grant is held, granted index
    bit [3:0] m_pend;
    bit       m_valid;
    int       m_code;
    int       m_last;
    bit       m_started = 1'b0;

    // first pending index in descending order starting at (last+3) mod 4
    function automatic int pick(bit [3:0] p, int last);
        for (int k = 3; k >= 0; k--) begin
            int idx;
            idx = (last + k) % 4;
            if (p[idx]) return idx;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        bit [3:0] np;
        m_started = 1'b1;
        if (rst) begin
            m_pend  = 4'b0000;
            m_valid = 1'b0;
            m_code  = 0;
            m_last  = 0;
        end else begin
            np = m_pend;
            if (m_valid && Ack) begin
                np[m_code] = 1'b0;
                m_valid    = 1'b0;
                m_last     = m_code;
            end else if (!m_valid && m_pend != 4'b0000) begin
                m_valid = 1'b1;
`ifdef FOUR_TWO_ROUND_ROBIN_EN
                m_code = pick(m_pend, m_last);
`else
                m_code = pick(m_pend, 0);
`endif
            end
            if (!Cs)
                for (int i = 0; i < 4; i++)
                    if (!Req_n[i]) np[i] = 1'b1;
            m_pend = np;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            checks++;
            if (Valid !== m_valid) begin
                errors++;
                $display("FAIL model_valid t=%0t got %b exp %b", $time, Valid, m_valid);
            end
            checks++;
            if ({A1, A0} !== 2'(m_code)) begin
                errors++;
                $display("FAIL model_code t=%0t got %b%b exp %0d", $time, A1, A0, m_code);
            end
            checks++;
            if (Pend !== m_pend) begin
                errors++;
                $display("FAIL model_pend t=%0t got %b exp %b", $time, Pend, m_pend);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic ack();
        Ack = 1'b1;
        step();
        Ack = 1'b0;
    endtask

    task automatic expect_out(string name, logic v, logic [1:0] c, logic [3:0] p);
        checks++;
        if (Valid !== v || {A1, A0} !== c || Pend !== p) begin
            errors++;
            $display("FAIL %s got valid=%b code=%b%b pend=%b exp valid=%b code=%b pend=%b",
                     name, Valid, A1, A0, Pend, v, c, p);
        end
    endtask

    initial begin
        rst   = 1'b1;
        Cs    = 1'b0;
        Req_n = 4'b0000;
        Ack   = 1'b0;

        step();
        expect_out("rst_hold0", 1'b0, 2'd0, 4'b0000);
        step();
        expect_out("rst_hold1", 1'b0, 2'd0, 4'b0000);
        rst = 1'b0;
        step();
        expect_out("rst_rel_pend", 1'b0, 2'd0, 4'b1111);
        step();
        expect_out("rst_rel_grant", 1'b1, 2'd3, 4'b1111);
        Req_n = 4'b1111;

        for (int c = 3; c >= 0; c--) begin
            expect_out("drain_grant", 1'b1, 2'(c), 4'((1 << (c + 1)) - 1));
            ack();
            expect_out("drain_ack", 1'b0, 2'(c), 4'((1 << c) - 1));
            if (c > 0) step();
        end

        Req_n = 4'b1010;
        step();
        expect_out("prio_cap", 1'b0, 2'd0, 4'b0101);
        Req_n = 4'b1111;
        step();
        expect_out("prio_first", 1'b1, 2'd2, 4'b0101);
        ack();
        expect_out("prio_idle", 1'b0, 2'd2, 4'b0001);
        step();
        expect_out("prio_second", 1'b1, 2'd0, 4'b0001);
        ack();
        expect_out("prio_done", 1'b0, 2'd0, 4'b0000);

        Req_n = 4'b1101;
        step();
        expect_out("single_cap", 1'b0, 2'd0, 4'b0010);
        Req_n = 4'b1111;
        step();
        expect_out("single_grant", 1'b1, 2'd1, 4'b0010);
        step();
        expect_out("single_hold", 1'b1, 2'd1, 4'b0010);
        ack();
        expect_out("single_ack", 1'b0, 2'd1, 4'b0000);

        Cs    = 1'b1;
        Req_n = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("cs_block", 1'b0, 2'd1, 4'b0000);
        end
        Cs    = 1'b0;
        Req_n = 4'b1101;
        step();
        expect_out("frz_cap", 1'b0, 2'd1, 4'b0010);
        Req_n = 4'b1111;
        step();
        expect_out("frz_grant", 1'b1, 2'd1, 4'b0010);
        Req_n = 4'b0111;
        step();
        expect_out("frz_new3", 1'b1, 2'd1, 4'b1010);
        Req_n = 4'b1111;
        step();
        expect_out("frz_hold", 1'b1, 2'd1, 4'b1010);
        ack();
        expect_out("frz_ack", 1'b0, 2'd1, 4'b1000);
        step();
        expect_out("frz_next", 1'b1, 2'd3, 4'b1000);
        ack();
        expect_out("frz_done", 1'b0, 2'd3, 4'b0000);

        ack();
        expect_out("ack_idle", 1'b0, 2'd3, 4'b0000);
        step();
        expect_out("ack_idle2", 1'b0, 2'd3, 4'b0000);

        Req_n = 4'b1011;
        step();
        expect_out("held_cap", 1'b0, 2'd3, 4'b0100);
        step();
        expect_out("held_grant", 1'b1, 2'd2, 4'b0100);
        ack();
        expect_out("held_repend", 1'b0, 2'd2, 4'b0100);
        step();
        expect_out("held_regrant", 1'b1, 2'd2, 4'b0100);
        Req_n = 4'b1111;
        ack();
        expect_out("held_done", 1'b0, 2'd2, 4'b0000);

        Req_n = 4'b1110;
        step();
        expect_out("rstg_cap", 1'b0, 2'd2, 4'b0001);
        Req_n = 4'b1111;
        step();
        expect_out("rstg_grant", 1'b1, 2'd0, 4'b0001);
        rst = 1'b1;
        step();
        expect_out("rstg_reset", 1'b0, 2'd0, 4'b0000);
        rst = 1'b0;
        step();
        expect_out("rstg_after", 1'b0, 2'd0, 4'b0000);

`ifdef FOUR_TWO_ROUND_ROBIN_EN
        begin
            int seq [5] = '{3, 2, 1, 0, 3};
            Req_n = 4'b0000;
            step();
            expect_out("rr_cap", 1'b0, 2'd0, 4'b1111);
            Req_n = 4'b1111;
            step();
            for (int n = 0; n < 5; n++) begin
                expect_out("rr_grant", 1'b1, 2'(seq[n]), 4'b1111);
                ack();
                expect_out("rr_ack", 1'b0, 2'(seq[n]),
                           4'b1111 & ~(4'b0001 << seq[n]));
                Req_n[seq[n]] = 1'b0;
                step();
                Req_n = 4'b1111;
            end
        end
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/four_two_priority_encoder.md
# four_two_priority_encoder

Registered 4-to-2 priority encoder with request capture and a valid/ack handshake. It is the encoding end of the active-low 2-to-4 select path: it takes up to four active-low request lines, latches them, and presents the winning index as a 2-bit code (A1, A0) held stable until the consumer acknowledges it. It sits between the requesters (interrupt or select sources) and the block that consumes the encoded index, typically one that re-decodes it into active-low selects.

## Interface
Parameters: none.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- Cs  input  1  active-low chip select; 1 blocks capture of new requests
- Req_n  input  4  active-low request lines; Req_n[i]=0 requests index i
- Ack  input  1  active-high acknowledge of the currently presented code
- A1  output  1  encoded index, MSB
- A0  output  1  encoded index, LSB
- Valid  output  1  high while {A1,A0} holds a granted, unacknowledged index
- Pend  output  4  current pending-request register, for observability

## Operation
- Pending register pend[3:0]:
  - Set rule: at each edge, pend[i] is set if Cs=0 and Req_n[i]=0.
  - Clear rule: pend[i] is cleared only by Ack while index i is granted.
  - Same-edge set and clear: set wins, so a request line held low re-pends immediately. Requesters must release the line before acking.
- Cs=1 blocks new captures only. It does not clear pend and does not abort an in-progress grant.
- FSM, two states:
  - IDLE: Valid=0. If pend≠0 at an edge, the next state is GRANT, the winning index is latched into {A1,A0}, and Valid goes to 1.
  - GRANT: Valid=1 and {A1,A0} are frozen. Later pending changes do not alter the code. On an edge with Ack=1, pend[{A1,A0}] is cleared, Valid goes to 0, and the state returns to IDLE.
- Ack while in IDLE is ignored and has no side effects.
- Fixed priority (default): index 3 is highest, index 0 is lowest.
- Selection reads the registered pend, not live Req_n.
- Reset values: pend=0, state=IDLE, A1=0, A0=0, Valid=0, round-robin pointer=0.
- Reset asserted mid-grant: all state returns to the reset values at that edge, and the grant is lost without being acked.

## Timing
- Request latency:
  - Req_n[i] sampled low at edge k sets pend[i] after edge k.
  - With the FSM in IDLE, Valid and the code assert after edge k+1.
  - Result: 2 cycles from a sampled request to Valid.
- Ack sampled at edge m: Valid=0 after edge m.
  - The earliest next Valid is after edge m+1, so there is at least one idle cycle between grants.
  - Back-to-back throughput is therefore one grant per 2 cycles minimum.
- {A1,A0} changes only on the IDLE→GRANT edge. It is glitch-free and register-driven.
- Pend reflects the register value. Updates to it are visible one cycle after the sampling edge.

## Configuration
- Macro: FOUR_TWO_ROUND_ROBIN_EN.
- Undefined: fixed priority, 3>2>1>0.
- Defined: rotating priority using a 2-bit pointer last.
  - last holds the most recently acked index.
  - Search order is descending, starting from (last+3) mod 4: (last+3), (last+2), (last+1), last, all mod 4.
  - last resets to 0, so the first search order is 3,2,1,0, identical to fixed priority.
  - last updates only on an acked grant.
- All other timing and handshake behaviour is identical in both builds.

## Test plan
- Reset check: hold rst=1 for 2 cycles with Req_n=0000 and Cs=0. Required: Valid=0, A1A0=00, Pend=0000 during reset. After release, Pend=1111 one cycle later and Valid=1 with A1A0=11 the cycle after.
- Single request: pulse Req_n=1101 (index 1) for one cycle with Cs=0. Required: Valid=1 and A1A0=01 two cycles later, held until Ack. Ack one cycle gives Valid=0 and Pend=0000.
- Fixed priority with Req_n=1010 (indices 0 and 2) pulsed together:
  - First grant is 10. Ack gives one idle cycle, then a second grant of 00.
  - Ack again gives Pend=0000.
- Cs gating and frozen code:
  - Cs=1 with Req_n=0000 for 3 cycles: Pend stays 0000 and Valid stays 0.
  - During a grant of 01, a new request on index 3 with Cs=0 sets Pend[3] but leaves A1A0=01 unchanged until Ack.
- Boundary cases: Ack in IDLE causes no change. Request held low across Ack re-pends the same index, which is re-granted after one idle cycle. rst asserted during GRANT clears Valid and Pend at that edge.
- FOUR_TWO_ROUND_ROBIN_EN build: hold all four requests pending continuously (re-pulse each after its ack). Required: grant sequence 3,2,1,0,3, each code granted exactly once per rotation.
